// File: rtl/pam4_pkg.sv
// PAM-4 receive shared definitions: symbol codes, ideal levels,
// packer state encoding and the reference slicer function.
package pam4_pkg;

    localparam logic [1:0] SYM_M3 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b10;
    localparam logic [1:0] SYM_P3 = 2'b11;

    localparam int LVL_M3 = -84;
    localparam int LVL_M1 = -28;
    localparam int LVL_P1 = 28;
    localparam int LVL_P3 = 84;

    localparam int SLICE_W = 16;

    typedef enum logic {
        PK_EMPTY,
        PK_FILL
    } pk_state_e;

    // Sample and threshold are passed sign/zero-extended to SLICE_W,
    // so the extremes of the sample range never overflow the compare.
    function automatic logic [1:0] slice(
        input logic signed [SLICE_W-1:0] v,
        input logic signed [SLICE_W-1:0] t
    );
        logic [1:0] s;
        if (v < -t) begin
            s = SYM_M3;
        end else if (v < 0) begin
            s = SYM_M1;
        end else if (v < t) begin
            s = SYM_P1;
        end else begin
            s = SYM_P3;
        end
        return s;
    endfunction

endpackage

// File: rtl/pam_4_symbol_packer.sv
// Packs 2-bit symbols MSB-first into bytes and discards a partial
// byte after GAP_TIMEOUT idle cycles.
module pam_4_symbol_packer
    import pam4_pkg::*;
#(
    parameter int GAP_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] sym_i,
    input  logic       sym_vld_i,
    output logic [7:0] byte_o,
    output logic       byte_vld_o,
    output logic       drop_o
);

    localparam int GW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

    pk_state_e     state_q;
    logic [1:0]    cnt_q;
    logic [5:0]    sh_q;
    logic [7:0]    byte_q;
    logic          bvld_q;
    logic [GW-1:0] gap_q;
    logic          timeout;

    // The idle cycle that would bring the counter to GAP_TIMEOUT is the
    // drop cycle; a valid symbol in that cycle takes priority.
    assign timeout = (state_q == PK_FILL) && !sym_vld_i
                     && (gap_q == GAP_LAST);

    // Packer FSM, gap timer and registered byte output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= PK_EMPTY;
            cnt_q   <= 2'd0;
            sh_q    <= 6'd0;
            byte_q  <= 8'd0;
            bvld_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            bvld_q <= 1'b0;
            unique case (state_q)
                PK_EMPTY: begin
                    gap_q <= '0;
                    if (sym_vld_i) begin
                        sh_q    <= {4'd0, sym_i};
                        cnt_q   <= 2'd1;
                        state_q <= PK_FILL;
                    end
                end
                PK_FILL: begin
                    if (sym_vld_i) begin
                        gap_q <= '0;
                        if (cnt_q == 2'd3) begin
                            byte_q  <= {sh_q, sym_i};
                            bvld_q  <= 1'b1;
                            cnt_q   <= 2'd0;
                            state_q <= PK_EMPTY;
                        end else begin
                            sh_q  <= {sh_q[3:0], sym_i};
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end else if (timeout) begin
                        gap_q   <= '0;
                        cnt_q   <= 2'd0;
                        sh_q    <= 6'd0;
                        state_q <= PK_EMPTY;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= PK_EMPTY;
                end
            endcase
        end
    end

    assign byte_o     = byte_q;
    assign byte_vld_o = bvld_q;
    assign drop_o     = timeout;

endmodule

// File: rtl/pam_4_decode.sv
// PAM-4 receive slicer and byte packer. Define PAM4_DECODE_ADAPT_EN
// to track the signal amplitude and adapt the slicing threshold.
module pam_4_decode
    import pam4_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int SYMBOL_SEPERATION = 56,
    parameter int GAP_TIMEOUT       = 16,
    parameter int ADAPT_SHIFT       = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic signed [SIGNAL_RESOLUTION-1:0] voltage_level_in,
    input  logic                                voltage_level_in_valid,
    output logic [1:0]                          symbol_out,
    output logic                                symbol_out_valid,
    output logic [7:0]                          byte_out,
    output logic                                byte_out_valid,
    output logic                                byte_drop,
    output logic [SIGNAL_RESOLUTION-1:0]        threshold_out
);

    localparam int N = SIGNAL_RESOLUTION;

    logic [N-1:0] thr;
    logic [1:0]   sym_d;
    logic [1:0]   sym_q;
    logic         vld_q;

`ifdef PAM4_DECODE_ADAPT_EN
    localparam int AW    = N + ADAPT_SHIFT;
    localparam int A_INT = 3 * SYMBOL_SEPERATION / 2;
    localparam int T_INT = (A_INT >> 1) + (A_INT >> 3) + (A_INT >> 5);
    localparam logic [AW-1:0] A_RST = AW'(A_INT << ADAPT_SHIFT);

    logic [AW-1:0]        amp_q;
    logic [AW-1:0]        amp_d;
    logic [N-1:0]         thr_q;
    logic [N-1:0]         thr_d;
    logic signed [N:0]    ext;
    logic [N:0]           mag;
    logic                 upd;
    logic signed [AW+1:0] diff;
    logic [AW-1:0]        ai;
    logic [AW-1:0]        tsum;

    // Amplitude IIR on outer-level samples and derived threshold ~2A/3.
    always_comb begin
        ext   = {voltage_level_in[N-1], voltage_level_in};
        mag   = ext[N] ? -ext : ext;
        upd   = voltage_level_in_valid && (mag >= {1'b0, thr_q});
        diff  = $signed({1'b0, mag, {ADAPT_SHIFT{1'b0}}})
              - $signed({2'b00, amp_q});
        amp_d = upd ? amp_q + AW'(diff >>> ADAPT_SHIFT) : amp_q;
        ai    = amp_d >> ADAPT_SHIFT;
        tsum  = (ai >> 1) + (ai >> 3) + (ai >> 5);
        thr_d = (tsum == '0) ? N'(1) : N'(tsum);
    end

    // Tracker state; the new threshold applies from the next sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            amp_q <= A_RST;
            thr_q <= N'(T_INT);
        end else begin
            amp_q <= amp_d;
            thr_q <= thr_d;
        end
    end

    assign thr = thr_q;
`else
    assign thr = N'(SYMBOL_SEPERATION);
`endif

    assign sym_d = slice(SLICE_W'(voltage_level_in), SLICE_W'(thr));

    // Registered slicer; the symbol holds while no sample is valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sym_q <= 2'd0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= voltage_level_in_valid;
            if (voltage_level_in_valid) begin
                sym_q <= sym_d;
            end
        end
    end

    pam_4_symbol_packer #(
        .GAP_TIMEOUT(GAP_TIMEOUT)
    ) u_packer (
        .clk       (clk),
        .rstn      (rstn),
        .sym_i     (sym_q),
        .sym_vld_i (vld_q),
        .byte_o    (byte_out),
        .byte_vld_o(byte_out_valid),
        .drop_o    (byte_drop)
    );

    assign symbol_out       = sym_q;
    assign symbol_out_valid = vld_q;
    assign threshold_out    = thr;

endmodule

// File: tb/tb_pam_4_decode.sv
// Directed bench for pam_4_decode: slicing table, byte packing,
// gap timeout, async reset and (adapt build) threshold tracking.
module tb_pam_4_decode;
    import pam4_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic signed [7:0] vin;
    logic              vvld;
    logic [1:0]        symbol_out;
    logic              symbol_out_valid;
    logic [7:0]        byte_out;
    logic              byte_out_valid;
    logic              byte_drop;
    logic [7:0]        threshold_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int drop_cnt = 0;
    int drop_cyc = 0;
    int last_sv  = 0;
    int nchk     = 0;
    int t4       = 0;
    int d0;
    logic [7:0] got_q[$];
    int         bcyc_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        logic signed [7:0] v;
        logic [1:0]        s;
    } vec_t;
    vec_t tab[12];

    pam_4_decode dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .voltage_level_in      (vin),
        .voltage_level_in_valid(vvld),
        .symbol_out            (symbol_out),
        .symbol_out_valid      (symbol_out_valid),
        .byte_out              (byte_out),
        .byte_out_valid        (byte_out_valid),
        .byte_drop             (byte_drop),
        .threshold_out         (threshold_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (byte_out_valid) begin
            got_q.push_back(byte_out);
            bcyc_q.push_back(cyc);
        end
        if (byte_drop) begin
            drop_cnt = drop_cnt + 1;
            drop_cyc = cyc;
        end
        if (symbol_out_valid) last_sv = cyc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic send(input logic signed [7:0] v);
        @(negedge clk);
        vin  = v;
        vvld = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            vvld = 1'b0;
        end
    endtask

    task automatic check_bytes(input string nm);
        idle(4);
        chk({nm, " count"}, got_q.size(), exp_q.size());
        for (int i = nchk; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s byte%0d", nm, i), got_q[i], exp_q[i]);
        end
        nchk = exp_q.size();
    endtask

    task automatic wait_drop(input int base);
        for (int k = 0; k < 40 && drop_cnt == base; k++) @(negedge clk);
        idle(5);
    endtask

    initial begin
        logic [7:0] bv;
        logic [1:0] s;
        logic signed [7:0] lv;

        vin  = 8'sd0;
        vvld = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst sym", symbol_out, 2'd0);
        chk("rst sym_v", symbol_out_valid, 1'b0);
        chk("rst byte", byte_out, 8'd0);
        chk("rst byte_v", byte_out_valid, 1'b0);
        chk("rst drop", byte_drop, 1'b0);
`ifdef PAM4_DECODE_ADAPT_EN
        chk("rst thr", threshold_out, 8'd54);
`else
        chk("rst thr", threshold_out, 8'd56);
`endif
        @(negedge clk);
        rstn = 1'b1;

`ifdef PAM4_DECODE_ADAPT_EN
        for (int b = 0; b < 500; b++) begin
            bv = 8'($urandom_range(0, 255));
            exp_q.push_back(bv);
            for (int j = 0; j < 4; j++) begin
                s = bv[7-2*j -: 2];
                unique case (s)
                    2'b00:   lv = -8'sd60;
                    2'b01:   lv = -8'sd20;
                    2'b10:   lv = 8'sd20;
                    default: lv = 8'sd60;
                endcase
                send(lv);
            end
        end
        check_bytes("adapt");
        chk("adapt thr", (threshold_out >= 8'd38) && (threshold_out <= 8'd42), 1);
        chk("adapt drop", drop_cnt, 0);
`else
        tab[0]  = '{v: -8'sd84,  s: SYM_M3};
        tab[1]  = '{v: -8'sd28,  s: SYM_M1};
        tab[2]  = '{v: 8'sd28,   s: SYM_P1};
        tab[3]  = '{v: 8'sd84,   s: SYM_P3};
        tab[4]  = '{v: -8'sd57,  s: SYM_M3};
        tab[5]  = '{v: -8'sd56,  s: SYM_M1};
        tab[6]  = '{v: -8'sd1,   s: SYM_M1};
        tab[7]  = '{v: 8'sd0,    s: SYM_P1};
        tab[8]  = '{v: 8'sd55,   s: SYM_P1};
        tab[9]  = '{v: 8'sd56,   s: SYM_P3};
        tab[10] = '{v: 8'h80,    s: SYM_M3};
        tab[11] = '{v: 8'sd127,  s: SYM_P3};

        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("sym_v[%0d]", i - 1), symbol_out_valid, 1'b1);
                chk($sformatf("sym[%0d]", i - 1), symbol_out, tab[i-1].s);
            end
            if (i < 12) begin
                vin  = tab[i].v;
                vvld = 1'b1;
                if (i == 3) t4 = cyc;
            end else begin
                vvld = 1'b0;
            end
        end
        @(negedge clk);
        chk("hold sym_v", symbol_out_valid, 1'b0);
        chk("hold sym", symbol_out, SYM_P3);
        exp_q.push_back(8'h1B);
        exp_q.push_back(8'h16);
        exp_q.push_back(8'hB3);
        check_bytes("table");
        chk("latency", (bcyc_q.size() > 0) ? bcyc_q[0] - t4 : -1, 2);
        chk("hold byte", byte_out, 8'hB3);
        chk("table drop", drop_cnt, 0);
        chk("thr", threshold_out, 8'd56);

        d0 = drop_cnt;
        send(-8'sd84);
        send(-8'sd28);
        send(8'sd28);
        idle(1);
        wait_drop(d0);
        chk("gap drop cnt", drop_cnt - d0, 1);
        chk("gap drop time", drop_cyc - last_sv, 16);
        repeat (4) send(8'sd84);
        exp_q.push_back(8'hFF);
        check_bytes("after drop");

        d0 = drop_cnt;
        repeat (3) send(-8'sd84);
        idle(15);
        send(8'sd84);
        exp_q.push_back(8'h03);
        check_bytes("late4");
        idle(20);
        chk("late4 drop", drop_cnt - d0, 0);

        d0 = drop_cnt;
        send(8'sd28);
        send(8'sd28);
        @(negedge clk);
        vvld = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst sym", symbol_out, 2'd0);
        chk("arst sym_v", symbol_out_valid, 1'b0);
        chk("arst byte", byte_out, 8'd0);
        chk("arst byte_v", byte_out_valid, 1'b0);
        chk("arst drop", byte_drop, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        send(-8'sd84);
        send(-8'sd84);
        send(8'sd84);
        send(8'sd84);
        exp_q.push_back(8'h0F);
        check_bytes("post rst");
        idle(20);
        chk("post rst drop", drop_cnt - d0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
